// File: rtl/fifo_axi_mem_bridge_if.sv
// AXI4 master/slave bundle between the memory bridge and the MIG.
// Burst attributes travel with the address channels.
interface fifo_axi_mem_bridge_if #(
  parameter int data_width = 32,
  parameter int addr_width = 32
);
  logic [addr_width-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic [3:0]              awid;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic                    awvalid;
  logic                    awready;

  logic [data_width-1:0]   wdata;
  logic [data_width/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [addr_width-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic [3:0]              arid;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic                    arvalid;
  logic                    arready;

  logic [data_width-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awlen, awsize, awburst, awid,
    output awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arlen, arsize, arburst, arid,
    output arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awid,
    input  awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst, arid,
    input  arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/fifo_axi_mem_bridge.sv
// FIFO-style memory command/data streams to AXI4 INCR bursts.
// Bursts are capped at max_burst beats and never cross 4 KB.
module fifo_axi_mem_bridge #(
  parameter int mem_width      = 32,
  parameter int addr_width     = 32,
  parameter int axi_addr_width = 32,
  parameter int max_burst      = 16,
  parameter int err_width      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mig_init_done,
  input  logic [2*addr_width:0]   cmd_data,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [mem_width-1:0]    wr_data,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  output logic [mem_width-1:0]    rd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  fifo_axi_mem_bridge_if.master   axi,
  output logic                    busy,
  output logic [err_width-1:0]    err_count
);

  localparam int sh = $clog2(mem_width/8);
  localparam int bw = addr_width + 9;

  typedef enum logic [2:0] {
    INIT, IDLE, W_ADDR, W_DATA, W_RESP, R_ADDR, R_DATA
  } state_t;

  state_t state;

  logic [addr_width-1:0]     addr_q;
  logic [addr_width-1:0]     rem_q;
  logic [axi_addr_width-1:0] axaddr_q;
  logic [7:0]                len_m1_q;
  logic [7:0]                beat_q;
  logic                      awvalid_q;
  logic                      arvalid_q;
  logic                      bready_q;
  logic [err_width-1:0]      err_q;

  logic                  cmd_wr;
  logic [addr_width-1:0] cmd_addr;
  logic [addr_width-1:0] cmd_cnt;
  logic [8:0]            cmd_len;
  logic [8:0]            cur_len;
  logic [8:0]            nxt_len;
  logic [addr_width-1:0] nxt_addr;
  logic [addr_width-1:0] nxt_rem;
  logic                  beat_last;
  logic                  w_fire;
  logic                  r_fire;
  logic [1:0]            r_inc;
  logic [1:0]            b_inc;

  function automatic logic [axi_addr_width-1:0] byte_addr(
    input logic [addr_width-1:0] a
  );
    logic [bw-1:0] w;
    w = bw'(a) << sh;
    return axi_addr_width'(w);
  endfunction

  // min(remaining, max_burst, beats left in this 4 KB page)
  function automatic logic [8:0] burst_len(
    input logic [addr_width-1:0] a,
    input logic [addr_width-1:0] r
  );
    logic [11:0] off;
    logic [12:0] room;
    logic [8:0]  n;
    off  = 12'(byte_addr(a));
    room = (13'h1000 - {1'b0, off}) >> sh;
    n    = 9'(max_burst);
    if (room < {4'b0, n}) n = room[8:0];
    if (bw'(r) < bw'(n)) n = 9'(r);
    return n;
  endfunction

  function automatic logic [err_width-1:0] sat_add(
    input logic [err_width-1:0] e,
    input logic [1:0]           inc
  );
    logic [err_width:0] s;
    s = {1'b0, e} + {{(err_width-1){1'b0}}, inc};
    return s[err_width] ? '1 : s[err_width-1:0];
  endfunction

  assign {cmd_wr, cmd_addr, cmd_cnt} = cmd_data;

  assign cmd_len  = burst_len(cmd_addr, cmd_cnt);
  assign cur_len  = {1'b0, len_m1_q} + 9'd1;
  assign nxt_addr = addr_q + addr_width'(cur_len);
  assign nxt_rem  = rem_q - addr_width'(cur_len);
  assign nxt_len  = burst_len(nxt_addr, nxt_rem);

  assign beat_last = (beat_q == len_m1_q);
  assign w_fire = (state == W_DATA) && wr_valid && axi.wready;
  assign r_fire = (state == R_DATA) && axi.rvalid && rd_ready;
  assign r_inc  = {1'b0, axi.rresp != 2'b00}
                + {1'b0, axi.rlast != beat_last};
  assign b_inc  = {1'b0, axi.bresp != 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= INIT;
      addr_q    <= '0;
      rem_q     <= '0;
      axaddr_q  <= '0;
      len_m1_q  <= '0;
      beat_q    <= '0;
      awvalid_q <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      err_q     <= '0;
    end else begin
      unique case (state)
        INIT: begin
          if (mig_init_done) state <= IDLE;
        end
        IDLE: begin
          if (cmd_valid && cmd_cnt != '0) begin
            addr_q   <= cmd_addr;
            rem_q    <= cmd_cnt;
            len_m1_q <= 8'(cmd_len - 9'd1);
            axaddr_q <= byte_addr(cmd_addr);
            beat_q   <= '0;
            if (cmd_wr) begin
              state     <= W_ADDR;
              awvalid_q <= 1'b1;
            end else begin
              state     <= R_ADDR;
              arvalid_q <= 1'b1;
            end
          end
        end
        W_ADDR: begin
          if (axi.awready) begin
            awvalid_q <= 1'b0;
            state     <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            beat_q <= beat_q + 8'd1;
            if (beat_last) begin
              bready_q <= 1'b1;
              state    <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (axi.bvalid) begin
            bready_q <= 1'b0;
            err_q    <= sat_add(err_q, b_inc);
            addr_q   <= nxt_addr;
            rem_q    <= nxt_rem;
            if (nxt_rem != '0) begin
              len_m1_q  <= 8'(nxt_len - 9'd1);
              axaddr_q  <= byte_addr(nxt_addr);
              beat_q    <= '0;
              awvalid_q <= 1'b1;
              state     <= W_ADDR;
            end else begin
              state <= IDLE;
            end
          end
        end
        R_ADDR: begin
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            state     <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_fire) begin
            err_q  <= sat_add(err_q, r_inc);
            beat_q <= beat_q + 8'd1;
            // our own beat count ends the burst, whatever rlast says
            if (beat_last) begin
              addr_q <= nxt_addr;
              rem_q  <= nxt_rem;
              if (nxt_rem != '0) begin
                len_m1_q  <= 8'(nxt_len - 9'd1);
                axaddr_q  <= byte_addr(nxt_addr);
                beat_q    <= '0;
                arvalid_q <= 1'b1;
                state     <= R_ADDR;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != INIT) && (state != IDLE);
  assign err_count = err_q;

  assign axi.awaddr  = axaddr_q;
  assign axi.awlen   = len_m1_q;
  assign axi.awsize  = 3'(sh);
  assign axi.awburst = 2'b01;
  assign axi.awid    = '0;
  assign axi.awlock  = 1'b0;
  assign axi.awcache = '0;
  assign axi.awprot  = '0;
  assign axi.awqos   = '0;
  assign axi.awvalid = awvalid_q;

  assign axi.wdata  = wr_data;
  assign axi.wstrb  = '1;
  assign axi.wlast  = (state == W_DATA) && beat_last;
  assign axi.wvalid = (state == W_DATA) && wr_valid;
  assign wr_ready   = (state == W_DATA) && axi.wready;

  assign axi.bready = bready_q;

  assign axi.araddr  = axaddr_q;
  assign axi.arlen   = len_m1_q;
  assign axi.arsize  = 3'(sh);
  assign axi.arburst = 2'b01;
  assign axi.arid    = '0;
  assign axi.arlock  = 1'b0;
  assign axi.arcache = '0;
  assign axi.arprot  = '0;
  assign axi.arqos   = '0;
  assign axi.arvalid = arvalid_q;

  assign rd_data    = axi.rdata;
  assign rd_valid   = (state == R_DATA) && axi.rvalid;
  assign axi.rready = (state == R_DATA) && rd_ready;

endmodule

// File: tb/tb_fifo_axi_mem_bridge.sv
// Directed bench for fifo_axi_mem_bridge with a small AXI slave model.
// Read data is 0xC0000000 xor byte address.
module tb_fifo_axi_mem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        mig_init_done;
  logic [64:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        busy;
  logic [15:0] err_count;

  fifo_axi_mem_bridge_if #(
    .data_width(32),
    .addr_width(32)
  ) axi ();

  fifo_axi_mem_bridge dut (
    .clk           (clk),
    .reset         (reset),
    .mig_init_done (mig_init_done),
    .cmd_data      (cmd_data),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .wr_data       (wr_data),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .axi           (axi),
    .busy          (busy),
    .err_count     (err_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  logic [31:0] aw_addr_q[$];
  int          aw_len_q[$];
  logic [31:0] ar_addr_q[$];
  int          ar_len_q[$];
  logic [31:0] w_data_q[$];
  bit          w_last_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] rb_addr_q[$];
  int          rb_len_q[$];
  int          r_beat = 0;
  int          b_pending = 0;
  int          b_cnt = 0;
  int          av_cnt = 0;
  int          cyc = 0;
  bit          w_gate = 0;
  bit          slverr_once = 0;
  bit          rlast_fault = 0;

  // Slave drives at negedge, samples settled handshakes 1 ns later.
  initial begin : slave
    axi.awready = 0;
    axi.wready  = 0;
    axi.bvalid  = 0;
    axi.bresp   = 0;
    axi.arready = 0;
    axi.rvalid  = 0;
    axi.rdata   = 0;
    axi.rresp   = 0;
    axi.rlast   = 0;
    forever begin
      @(negedge clk);
      cyc++;
      axi.awready = 1'b1;
      axi.arready = 1'b1;
      axi.wready  = w_gate ? (cyc % 2 == 0) : 1'b1;
      axi.bvalid  = (b_pending > 0);
      axi.bresp   = slverr_once ? 2'b10 : 2'b00;
      axi.rresp   = 2'b00;
      if (rb_len_q.size() > 0) begin
        axi.rvalid = 1'b1;
        axi.rdata  = 32'hC000_0000
                   ^ (rb_addr_q[0] + 32'(4 * r_beat));
        axi.rlast  = (r_beat == rb_len_q[0])
                   || (rlast_fault && r_beat == 1);
      end else begin
        axi.rvalid = 1'b0;
        axi.rdata  = '0;
        axi.rlast  = 1'b0;
      end
      #1;
      if (axi.awvalid || axi.arvalid) av_cnt++;
      if (axi.awvalid && axi.awready) begin
        aw_addr_q.push_back(axi.awaddr);
        aw_len_q.push_back(int'(axi.awlen));
      end
      if (axi.wvalid && axi.wready) begin
        w_data_q.push_back(axi.wdata);
        w_last_q.push_back(axi.wlast);
        if (axi.wlast) b_pending++;
      end
      if (axi.bvalid && axi.bready) begin
        b_pending--;
        b_cnt++;
        slverr_once = 0;
      end
      if (axi.arvalid && axi.arready) begin
        ar_addr_q.push_back(axi.araddr);
        ar_len_q.push_back(int'(axi.arlen));
        rb_addr_q.push_back(axi.araddr);
        rb_len_q.push_back(int'(axi.arlen));
      end
      if (axi.rvalid && axi.rready) begin
        r_beat++;
        if (r_beat > rb_len_q[0]) begin
          void'(rb_addr_q.pop_front());
          void'(rb_len_q.pop_front());
          r_beat = 0;
        end
      end
      if (rd_valid && rd_ready) rd_q.push_back(rd_data);
    end
  end

  task automatic clear_logs();
    aw_addr_q.delete();
    aw_len_q.delete();
    ar_addr_q.delete();
    ar_len_q.delete();
    w_data_q.delete();
    w_last_q.delete();
    rd_q.delete();
    b_cnt = 0;
  endtask

  task automatic send_cmd(
    input bit          w,
    input logic [31:0] a,
    input logic [31:0] n
  );
    bit ok;
    ok = 0;
    cmd_data = {w, a, n};
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      cmd_valid = 1'b1;
      #1;
      ok = cmd_ready;
    end
    check("cmd_accept", ok, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send_wr(
    input int          n,
    input logic [31:0] base,
    input bit          gate
  );
    int idx;
    int k;
    bit hold;
    idx = 0;
    k = 0;
    hold = 0;
    while (idx < n && k < 400) begin
      @(negedge clk);
      k++;
      wr_valid = (!gate || hold) ? 1'b1 : ~wr_valid;
      wr_data  = base + 32'(idx);
      #1;
      if (wr_valid && wr_ready) begin
        idx++;
        hold = 0;
      end else begin
        hold = wr_valid;
      end
    end
    check("wr_done", idx, n);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = !busy;
    end
    check(tag, ok, 1);
  endtask

  logic [31:0] exp_ar_addr[4];
  int          exp_ar_len[4];

  initial begin : main
    bit seen;
    bit ok;
    int w_snap;
    int av_snap;

    reset = 1'b1;
    mig_init_done = 1'b0;
    cmd_valid = 1'b0;
    cmd_data = '0;
    wr_valid = 1'b0;
    wr_data = '0;
    rd_ready = 1'b1;

    #3;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_count, 0);
    check("rst_valids",
          {axi.awvalid, axi.arvalid, axi.wvalid,
           axi.bready, axi.rready, rd_valid, wr_ready}, 0);
    check("rst_awaddr", axi.awaddr, 0);
    check("rst_awlen", axi.awlen, 0);

    @(negedge clk);
    reset = 1'b0;

    // startup gate, then a zero-length command
    cmd_data = {1'b0, 32'h55, 32'h0};
    cmd_valid = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (cmd_ready) seen = 1;
    end
    check("init_gate_ready", seen, 0);
    check("init_gate_busy", busy, 0);
    @(negedge clk);
    mig_init_done = 1'b1;
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = cmd_ready;
    end
    check("init_ready_seen", ok, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("zero_cnt_no_ax", av_cnt, 0);
    check("zero_cnt_idle", {busy, cmd_ready}, 2'b01);

    // single 4-beat write
    clear_logs();
    send_cmd(1'b1, 32'h100, 32'd4);
    send_wr(4, 32'h1111_0000, 1'b0);
    wait_idle("wr_idle");
    check("wr_aw_cnt", aw_addr_q.size(), 1);
    check("wr_awaddr", aw_addr_q[0], 32'h400);
    check("wr_awlen", aw_len_q[0], 3);
    check("wr_w_cnt", w_data_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wr_data%0d", i),
            w_data_q[i], 32'h1111_0000 + 32'(i));
      check($sformatf("wr_last%0d", i),
            w_last_q[i], (i == 3));
    end
    check("wr_b_cnt", b_cnt, 1);
    check("wr_err", err_count, 0);
    check("wr_cmd_ready", cmd_ready, 1);

    // 40-word read across the 4 KB boundary at word 0x400
    clear_logs();
    send_cmd(1'b0, 32'h3FC, 32'd40);
    wait_idle("rd_idle");
    exp_ar_addr = '{32'hFF0, 32'h1000, 32'h1040, 32'h1080};
    exp_ar_len  = '{3, 15, 15, 3};
    check("rd_ar_cnt", ar_addr_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rd_araddr%0d", i),
            ar_addr_q[i], exp_ar_addr[i]);
      check($sformatf("rd_arlen%0d", i),
            ar_len_q[i], exp_ar_len[i]);
    end
    check("rd_beats", rd_q.size(), 40);
    for (int i = 0; i < 40; i++) begin
      check($sformatf("rd_data%0d", i), rd_q[i],
            32'hC000_0000 ^ ((32'h3FC + 32'(i)) * 4));
    end
    check("rd_err", err_count, 0);

    // 16-beat write with both sides throttled
    clear_logs();
    w_gate = 1;
    send_cmd(1'b1, 32'h200, 32'd16);
    send_wr(16, 32'h2222_0000, 1'b1);
    wait_idle("gw_idle");
    w_gate = 0;
    check("gw_aw_cnt", aw_addr_q.size(), 1);
    check("gw_awaddr", aw_addr_q[0], 32'h800);
    check("gw_awlen", aw_len_q[0], 15);
    check("gw_w_cnt", w_data_q.size(), 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("gw_data%0d", i),
            w_data_q[i], 32'h2222_0000 + 32'(i));
      check($sformatf("gw_last%0d", i),
            w_last_q[i], (i == 15));
    end
    check("gw_err", err_count, 0);

    // SLVERR on a write, early rlast on a read
    clear_logs();
    slverr_once = 1;
    send_cmd(1'b1, 32'h300, 32'd4);
    send_wr(4, 32'h3333_0000, 1'b0);
    wait_idle("flt_w_idle");
    check("flt_b_err", err_count, 1);
    rlast_fault = 1;
    send_cmd(1'b0, 32'h40, 32'd4);
    wait_idle("flt_r_idle");
    rlast_fault = 0;
    check("flt_err", err_count, 2);
    check("flt_arlen", ar_len_q[0], 3);
    check("flt_rd_beats", rd_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("flt_rd%0d", i), rd_q[i],
            32'hC000_0000 ^ ((32'h40 + 32'(i)) * 4));
    end

    // reset in the middle of a write burst
    clear_logs();
    send_cmd(1'b1, 32'h500, 32'd8);
    send_wr(2, 32'h4444_0000, 1'b0);
    wr_valid = 1'b1;
    wr_data = 32'h4444_0002;
    #1;
    check("pre_rst_busy", busy, 1);
    check("pre_rst_wvalid", axi.wvalid, 1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_valids",
          {axi.awvalid, axi.arvalid, axi.wvalid,
           axi.bready, axi.rready, rd_valid, wr_ready}, 0);
    check("mid_rst_init", {busy, cmd_ready}, 2'b00);
    check("mid_rst_err", err_count, 0);
    repeat (2) @(negedge clk);
    w_snap = w_data_q.size();
    av_snap = av_cnt;
    reset = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("post_rst_no_w", w_data_q.size(), w_snap);
    check("post_rst_no_ax", av_cnt, av_snap);
    check("post_rst_idle", {busy, cmd_ready}, 2'b01);
    wr_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
